time_set_controller: RTL and testbench
======================================

Name: time_set_controller

Overview:
User-facing time-set controller for the greenhouse timekeeper. It debounces the mode/up/down push buttons and runs a RUN -> SET_HOUR -> SET_MIN edit sequence with auto-repeat. On confirmation it issues a one-cycle load strobe carrying the new hours/minutes to the timekeeper. The block sits between the board buttons and the timekeeper's load port; the timekeeper zeroes its seconds on time_load.

Parameters:
DEBOUNCE_CYCLES, 500_000, consecutive stable synchronized cycles needed to accept a button level change (10 ms at 50 MHz)
REPEAT_DELAY, 25_000_000, cycles from a press event to the first auto-repeat step (0.5 s)
REPEAT_PERIOD, 12_500_000, cycles between subsequent auto-repeat steps (0.25 s)
TIMEOUT_CYCLES, 500_000_000, idle cycles in an edit state before abandoning the edit (10 s)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  synchronous reset, active-low
btn_mode  in  1  raw mode button, active-high, asynchronous
btn_up  in  1  raw up button, active-high, asynchronous
btn_down  in  1  raw down button, active-high, asynchronous
cur_hours  in  5  current hours from timekeeper, 0-23
cur_minutes  in  6  current minutes from timekeeper, 0-59
set_hours  out  5  edit/load hours value, 0-23
set_minutes  out  6  edit/load minutes value, 0-59
time_load  out  1  one-cycle strobe; timekeeper loads set_hours/set_minutes and seconds=0
set_mode  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN; 3 never driven

Behaviour:
- Reset (rst_n=0 at a clk edge): state RUN, set_hours=0, set_minutes=0, time_load=0, set_mode=0. Debounced levels=0, all counters=0. Reset mid-edit abandons the edit with no load.
- Input path per button: 2-flop synchronizer, then a debounce counter. The counter clears whenever the synced level equals the debounced level. When the synced level differs for DEBOUNCE_CYCLES consecutive cycles, the debounced level flips. A glitch shorter than that produces no event.
- Press event = 1-cycle pulse on a debounced 0->1 transition. A button held through reset yields a press event once debounce completes after reset.
- Step (up/down only): a step is generated on the press event. While held, the next step comes REPEAT_DELAY cycles after the press event, then one every REPEAT_PERIOD cycles. Release clears the repeat counter.
- If up and down are both debounced-high, no steps are generated and both repeat counters are held at 0.
- FSM:
  - RUN: set_* hold their last loaded value. Mode press: capture cur_hours/cur_minutes into set_hours/set_minutes, go to SET_HOUR. Up/down are ignored.
  - SET_HOUR: up step increments hours, 23->0 wraps. Down step decrements, 0->23 wraps. Mode press goes to SET_MIN.
  - SET_MIN: up step increments minutes, 59->0 wraps. Down step decrements, 0->59 wraps. Hours are untouched (no carry). Mode press goes to LOAD.
  - LOAD (internal, one cycle): time_load=1 with set_* stable, then RUN. set_mode reads 2 during LOAD.
- Simultaneous mode press and up/down step in the same cycle: mode wins and the step is discarded.
- Timeout: the idle counter resets on any press event or step. If it reaches TIMEOUT_CYCLES in SET_HOUR or SET_MIN, the FSM returns to RUN, time_load stays 0, and set_* revert to the value held before the edit began.
- Arithmetic is modulo only; no out-of-range value is ever driven on set_*.
- Latency: set_* update the cycle after the step; time_load asserts the cycle after the confirming mode press event.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, TIMEOUT_CYCLES=200.)
1. Assert rst_n=0 for 2 cycles with buttons pressed -> set_hours=0, set_minutes=0, time_load=0, set_mode=0.
2. cur=13:45. Press mode, up x2, mode, down x1, mode (each press 10 cycles, 10-cycle gaps) -> exactly one time_load pulse with set_hours=15, set_minutes=44; set_mode returns to 0.
3. Wrap checks: SET_HOUR at 23 plus up -> 0. SET_MIN at 0 plus down -> 59, hours unchanged. Also 1-2 cycle pulses on btn_up and a 3-cycle bounce -> no step.
4. Auto-repeat: SET_MIN at 10, hold btn_up 40 cycles past the press event -> steps at +0, +20, +28, +36, giving set_minutes=14. Hold up and down together for 60 cycles -> no change.
5. Timeout: cur=08:30, enter SET_HOUR, step up to 9, then idle 200 cycles -> set_mode=0, time_load never asserted, set_hours=0, set_minutes=0 (pre-edit values after reset).
6. Reset mid-edit: assert rst_n=0 during SET_MIN -> RUN with no time_load. A same-cycle mode press plus up step in SET_HOUR -> transition to SET_MIN with hours unchanged.

Source files
------------

// File: rtl/time_set_controller_if.sv
// Board-side bundle for the time-set controller: raw buttons, timekeeper readback, load port.
interface time_set_controller_if;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic [4:0] set_hours;
    logic [5:0] set_minutes;
    logic       time_load;
    logic [1:0] set_mode;

    // The controller drives the timekeeper load port.
    modport master (
        input  btn_mode,
        input  btn_up,
        input  btn_down,
        input  cur_hours,
        input  cur_minutes,
        output set_hours,
        output set_minutes,
        output time_load,
        output set_mode
    );

    modport slave (
        output btn_mode,
        output btn_up,
        output btn_down,
        output cur_hours,
        output cur_minutes,
        input  set_hours,
        input  set_minutes,
        input  time_load,
        input  set_mode
    );
endinterface

// File: rtl/time_set_controller.sv
// Debounced mode/up/down buttons driving a RUN -> SET_HOUR -> SET_MIN -> LOAD edit sequence
// with auto-repeat and idle timeout; issues a one-cycle load strobe to the timekeeper.
module time_set_controller #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 12_500_000,
    parameter int TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    time_set_controller_if.master bus
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_LOAD     = 2'd3
    } state_t;

    // Index 0 = mode, 1 = up, 2 = down.
    logic [2:0] btn_raw;
    logic [2:0] press;
    logic [2:1] deb_lvl;
    logic [1:0] step;
    logic       both_held;

    assign btn_raw = {bus.btn_down, bus.btn_up, bus.btn_mode};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic            sync1_q;
            logic            sync2_q;
            logic            deb_q;
            logic            deb_prev_q;
            logic [DB_W-1:0] cnt_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync1_q    <= 1'b0;
                    sync2_q    <= 1'b0;
                    deb_q      <= 1'b0;
                    deb_prev_q <= 1'b0;
                    cnt_q      <= '0;
                end else begin
                    sync1_q    <= btn_raw[gi];
                    sync2_q    <= sync1_q;
                    deb_prev_q <= deb_q;
                    if (sync2_q == deb_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        // Nth consecutive differing cycle: accept the new level.
                        deb_q <= sync2_q;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + DB_W'(1);
                    end
                end
            end

            assign press[gi] = deb_q & ~deb_prev_q;

            if (gi != 0) begin : g_lvl
                assign deb_lvl[gi] = deb_q;
            end
        end
    endgenerate

    assign both_held = deb_lvl[1] & deb_lvl[2];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rpt
            logic [RP_W-1:0] rcnt_q;
            logic            repeating_q;
            logic [RP_W-1:0] target;
            logic            hit;

            // First repeat waits REPEAT_DELAY from the press; later ones REPEAT_PERIOD.
            assign target = repeating_q ? RP_W'(REPEAT_PERIOD) : RP_W'(REPEAT_DELAY);
            assign hit    = deb_lvl[gi+1] && !both_held && (rcnt_q == target);
            assign step[gi] = !both_held && (press[gi+1] || hit);

            always_ff @(posedge clk) begin
                if (!rst_n || !deb_lvl[gi+1] || both_held) begin
                    rcnt_q      <= '0;
                    repeating_q <= 1'b0;
                end else if (hit) begin
                    rcnt_q      <= RP_W'(1);
                    repeating_q <= 1'b1;
                end else begin
                    rcnt_q <= rcnt_q + RP_W'(1);
                end
            end
        end
    endgenerate

    state_t            state_q, state_d;
    logic [4:0]        edit_hours_q, edit_hours_d;
    logic [5:0]        edit_min_q, edit_min_d;
    logic [4:0]        load_hours_q, load_hours_d;
    logic [5:0]        load_min_q, load_min_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              activity;
    logic              timeout;
    logic              step_up;
    logic              step_down;

    assign step_up   = step[0];
    assign step_down = step[1];
    assign activity  = (|press) | (|step);
    assign timeout   = (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) && !activity;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            edit_hours_q <= 5'd0;
            edit_min_q   <= 6'd0;
            load_hours_q <= 5'd0;
            load_min_q   <= 6'd0;
            idle_q       <= '0;
        end else begin
            state_q      <= state_d;
            edit_hours_q <= edit_hours_d;
            edit_min_q   <= edit_min_d;
            load_hours_q <= load_hours_d;
            load_min_q   <= load_min_d;
            idle_q       <= idle_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        edit_hours_d = edit_hours_q;
        edit_min_d   = edit_min_q;
        load_hours_d = load_hours_q;
        load_min_d   = load_min_q;
        idle_d       = '0;

        case (state_q)
            ST_RUN: begin
                if (press[0]) begin
                    // Out-of-range readback is sanitised so set_* never leave 0-23 / 0-59.
                    edit_hours_d = (bus.cur_hours > 5'd23) ? 5'd0 : bus.cur_hours;
                    edit_min_d   = (bus.cur_minutes > 6'd59) ? 6'd0 : bus.cur_minutes;
                    state_d      = ST_SET_HOUR;
                end
            end
            ST_SET_HOUR: begin
                idle_d = activity ? '0 : idle_q + IDLE_W'(1);
                if (press[0]) begin
                    state_d = ST_SET_MIN;
                end else if (timeout) begin
                    state_d = ST_RUN;
                end else if (step_up) begin
                    edit_hours_d = (edit_hours_q == 5'd23) ? 5'd0 : edit_hours_q + 5'd1;
                end else if (step_down) begin
                    edit_hours_d = (edit_hours_q == 5'd0) ? 5'd23 : edit_hours_q - 5'd1;
                end
            end
            ST_SET_MIN: begin
                idle_d = activity ? '0 : idle_q + IDLE_W'(1);
                if (press[0]) begin
                    state_d = ST_LOAD;
                end else if (timeout) begin
                    state_d = ST_RUN;
                end else if (step_up) begin
                    edit_min_d = (edit_min_q == 6'd59) ? 6'd0 : edit_min_q + 6'd1;
                end else if (step_down) begin
                    edit_min_d = (edit_min_q == 6'd0) ? 6'd59 : edit_min_q - 6'd1;
                end
            end
            ST_LOAD: begin
                load_hours_d = edit_hours_q;
                load_min_d   = edit_min_q;
                state_d      = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // In RUN the last loaded value is shown, so an abandoned edit reverts automatically.
    assign bus.set_hours   = (state_q == ST_RUN) ? load_hours_q : edit_hours_q;
    assign bus.set_minutes = (state_q == ST_RUN) ? load_min_q : edit_min_q;
    assign bus.time_load   = (state_q == ST_LOAD);
    assign bus.set_mode    = (state_q == ST_LOAD) ? 2'd2 : state_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with short debounce/repeat/timeout parameters.
module tb_time_set_controller;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   load_cnt;
    int   load_h;
    int   load_m;
    int   load_mode;

    time_set_controller_if bus();

    time_set_controller #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every load strobe with the value and mode seen during it.
    always @(negedge clk) begin
        if (bus.time_load === 1'b1) begin
            load_cnt  = load_cnt + 1;
            load_h    = int'(bus.set_hours);
            load_m    = int'(bus.set_minutes);
            load_mode = int'(bus.set_mode);
            $display("load: %02d:%02d mode=%0d", load_h, load_m, load_mode);
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // btn: 0 = mode, 1 = up, 2 = down
    task automatic drive_btn(input int btn, input logic v);
        case (btn)
            0:       bus.btn_mode = v;
            1:       bus.btn_up   = v;
            default: bus.btn_down = v;
        endcase
    endtask

    task automatic press(input int btn);
        drive_btn(btn, 1'b1);
        tick(10);
        drive_btn(btn, 1'b0);
        tick(10);
    endtask

    task automatic pulse_up(input int len);
        bus.btn_up = 1'b1;
        tick(len);
        bus.btn_up = 1'b0;
        tick(8);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        load_cnt        = 0;
        load_h          = 0;
        load_m          = 0;
        load_mode       = 0;
        rst_n           = 1'b0;
        bus.btn_mode    = 1'b1;
        bus.btn_up      = 1'b1;
        bus.btn_down    = 1'b0;
        bus.cur_hours   = 5'd0;
        bus.cur_minutes = 6'd0;

        // 1: reset with buttons held
        tick(2);
        check_val("rst_hours", int'(bus.set_hours), 0);
        check_val("rst_minutes", int'(bus.set_minutes), 0);
        check_val("rst_load", int'(bus.time_load), 0);
        check_val("rst_mode", int'(bus.set_mode), 0);
        rst_n = 1'b1;
        tick(10);
        check_val("held_through_rst_mode", int'(bus.set_mode), 1);
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        tick(10);
        do_reset();
        check_val("rst2_mode", int'(bus.set_mode), 0);

        // 2: 13:45 -> 15:44
        bus.cur_hours   = 5'd13;
        bus.cur_minutes = 6'd45;
        press(0);
        check_val("t2_mode_hour", int'(bus.set_mode), 1);
        check_val("t2_capture_h", int'(bus.set_hours), 13);
        check_val("t2_capture_m", int'(bus.set_minutes), 45);
        press(1);
        press(1);
        check_val("t2_hours15", int'(bus.set_hours), 15);
        press(0);
        check_val("t2_mode_min", int'(bus.set_mode), 2);
        press(2);
        check_val("t2_min44", int'(bus.set_minutes), 44);
        press(0);
        check_val("t2_load_cnt", load_cnt, 1);
        check_val("t2_load_h", load_h, 15);
        check_val("t2_load_m", load_m, 44);
        check_val("t2_load_mode", load_mode, 2);
        check_val("t2_run_mode", int'(bus.set_mode), 0);
        check_val("t2_run_h", int'(bus.set_hours), 15);
        check_val("t2_run_m", int'(bus.set_minutes), 44);

        // 3: wraps and glitch rejection
        bus.cur_hours   = 5'd23;
        bus.cur_minutes = 6'd0;
        press(0);
        check_val("t3_h23", int'(bus.set_hours), 23);
        press(1);
        check_val("t3_h_up_wrap", int'(bus.set_hours), 0);
        press(2);
        check_val("t3_h_down_wrap", int'(bus.set_hours), 23);
        press(1);
        press(0);
        press(2);
        check_val("t3_m_down_wrap", int'(bus.set_minutes), 59);
        check_val("t3_h_no_carry", int'(bus.set_hours), 0);
        pulse_up(1);
        pulse_up(2);
        pulse_up(3);
        bus.btn_up = 1'b1; tick(2);
        bus.btn_up = 1'b0; tick(1);
        bus.btn_up = 1'b1; tick(2);
        bus.btn_up = 1'b0; tick(8);
        check_val("t3_glitch_no_step", int'(bus.set_minutes), 59);
        press(1);
        check_val("t3_m_up_wrap", int'(bus.set_minutes), 0);
        check_val("t3_h_still0", int'(bus.set_hours), 0);
        press(0);
        check_val("t3_load_cnt", load_cnt, 2);
        check_val("t3_load_m", load_m, 0);

        // 4: auto-repeat and both-held suppression
        bus.cur_hours   = 5'd5;
        bus.cur_minutes = 6'd10;
        press(0);
        press(0);
        check_val("t4_mode_min", int'(bus.set_mode), 2);
        bus.btn_up = 1'b1;
        tick(20);
        check_val("t4_rpt_first", int'(bus.set_minutes), 11);
        tick(20);
        check_val("t4_rpt_mid", int'(bus.set_minutes), 13);
        bus.btn_up = 1'b0;
        tick(12);
        check_val("t4_rpt_final", int'(bus.set_minutes), 14);
        bus.btn_up   = 1'b1;
        bus.btn_down = 1'b1;
        tick(60);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        tick(12);
        check_val("t4_both_held", int'(bus.set_minutes), 14);
        press(0);
        check_val("t4_load_cnt", load_cnt, 3);
        check_val("t4_load_h", load_h, 5);
        check_val("t4_load_m", load_m, 14);

        // 5: timeout reverts to pre-edit value
        do_reset();
        bus.cur_hours   = 5'd8;
        bus.cur_minutes = 6'd30;
        press(0);
        check_val("t5_h8", int'(bus.set_hours), 8);
        press(1);
        check_val("t5_h9", int'(bus.set_hours), 9);
        tick(140);
        check_val("t5_still_edit", int'(bus.set_mode), 1);
        tick(60);
        check_val("t5_timeout_mode", int'(bus.set_mode), 0);
        check_val("t5_revert_h", int'(bus.set_hours), 0);
        check_val("t5_revert_m", int'(bus.set_minutes), 0);
        check_val("t5_no_load", load_cnt, 3);

        // 6: mode beats a same-cycle step; reset mid-edit
        bus.cur_hours   = 5'd12;
        bus.cur_minutes = 6'd34;
        press(0);
        bus.btn_mode = 1'b1;
        bus.btn_up   = 1'b1;
        tick(10);
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        tick(10);
        check_val("t6_mode_wins", int'(bus.set_mode), 2);
        check_val("t6_h_unchanged", int'(bus.set_hours), 12);
        rst_n = 1'b0;
        tick(2);
        check_val("t6_rst_mode", int'(bus.set_mode), 0);
        check_val("t6_rst_h", int'(bus.set_hours), 0);
        rst_n = 1'b1;
        tick(10);
        check_val("t6_after_mode", int'(bus.set_mode), 0);
        check_val("t6_no_load", load_cnt, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
